// File: rtl/guess_engine_if.sv
// Hangman core bundle: round control, guess input and game status in one port.
// Latency: none (wires only); the engine registers every output.
// Backpressure: none; start/load/hint are single-cycle pulses that are always accepted.
//
// Signals (master = word store / keyboard side, slave = guess_engine):
//   start, target_mask  : begin a round with the given letter set
//   load, load_x        : present a guessed letter index
//   hint                : reveal request (only with GUESS_ENGINE_HINT_EN defined)
//   guessed_mask, game_state, wrong_time, hit, miss, repeat_guess, wins, losses : status
interface guess_engine_if #(
    parameter int ALPHA    = 26,
    parameter int LETTER_W = 5,
    parameter int WRONG_W  = 4
);
    logic                start;
    logic [ALPHA-1:0]    target_mask;
    logic                load;
    logic [LETTER_W-1:0] load_x;
`ifdef GUESS_ENGINE_HINT_EN
    logic                hint;
`endif
    logic [ALPHA-1:0]    guessed_mask;
    logic [1:0]          game_state;
    logic [WRONG_W-1:0]  wrong_time;
    logic                hit;
    logic                miss;
    logic                repeat_guess;
    logic [7:0]          wins;
    logic [7:0]          losses;

`ifdef GUESS_ENGINE_HINT_EN
    modport master (
        output start, target_mask, load, load_x, hint,
        input  guessed_mask, game_state, wrong_time, hit, miss, repeat_guess, wins, losses
    );
    modport slave (
        input  start, target_mask, load, load_x, hint,
        output guessed_mask, game_state, wrong_time, hit, miss, repeat_guess, wins, losses
    );
`else
    modport master (
        output start, target_mask, load, load_x,
        input  guessed_mask, game_state, wrong_time, hit, miss, repeat_guess, wins, losses
    );
    modport slave (
        input  start, target_mask, load, load_x,
        output guessed_mask, game_state, wrong_time, hit, miss, repeat_guess, wins, losses
    );
`endif
endinterface

// File: rtl/guess_engine.sv
// Hangman game core: target letter set, guess processing, outcome and win/loss totals.
// Latency: a start/load/hint sampled at edge N is reflected on every output after edge N.
// Backpressure: none; every pulse is consumed the cycle it is sampled (or dropped if illegal).
//
// Ports: clk, resetn (async active-low), bus (guess_engine_if.slave).
// Optional feature macro: GUESS_ENGINE_HINT_EN adds the hint request (reveal lowest
// unguessed target letter at the cost of one miss).
module guess_engine #(
    parameter int ALPHA     = 26,
    parameter int LETTER_W  = 5,
    parameter int MAX_WRONG = 6,
    parameter int WRONG_W   = 4
) (
    input  logic          clk,
    input  logic          resetn,
    guess_engine_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_PLAY = 2'b01,
        ST_WON  = 2'b10,
        ST_LOST = 2'b11
    } state_t;

    state_t             state_q,   state_d;
    logic [ALPHA-1:0]   target_q,  target_d;
    logic [ALPHA-1:0]   guessed_q, guessed_d;
    logic [WRONG_W-1:0] wrong_q,   wrong_d;
    logic [7:0]         wins_q,    wins_d;
    logic [7:0]         losses_q,  losses_d;
    logic               hit_q,     hit_d;
    logic               miss_q,    miss_d;
    logic               rep_q,     rep_d;

    logic [LETTER_W-1:0] letter;
    logic [ALPHA-1:0]    letter_onehot;
    logic                letter_valid;
    logic                eval;

    assign letter        = bus.load_x;
    // Shifting past the top of the alphabet yields zero, which doubles as the range check.
    assign letter_onehot = ALPHA'(1) << letter;
    assign letter_valid  = |letter_onehot;

`ifdef GUESS_ENGINE_HINT_EN
    logic [ALPHA-1:0] remaining;
    logic [ALPHA-1:0] reveal;
    assign remaining = target_q & ~guessed_q;
    // x & -x isolates the lowest set bit: the lowest-index letter still hidden.
    assign reveal    = remaining & (~remaining + ALPHA'(1));
`endif

    always_comb begin
        state_d   = state_q;
        target_d  = target_q;
        guessed_d = guessed_q;
        wrong_d   = wrong_q;
        wins_d    = wins_q;
        losses_d  = losses_q;
        hit_d     = 1'b0;
        miss_d    = 1'b0;
        rep_d     = 1'b0;
        eval      = 1'b0;

        if (bus.start) begin
            // A start always swallows any load/hint in the same cycle, even an empty one.
            if (|bus.target_mask) begin
                target_d  = bus.target_mask;
                guessed_d = '0;
                wrong_d   = '0;
                state_d   = ST_PLAY;
            end
        end else if (state_q == ST_PLAY) begin
            if (bus.load) begin
                if (letter_valid) begin
                    if (|(guessed_q & letter_onehot)) begin
                        rep_d = 1'b1;
                    end else begin
                        guessed_d = guessed_q | letter_onehot;
                        eval      = 1'b1;
                        if (|(target_q & letter_onehot)) begin
                            hit_d = 1'b1;
                        end else begin
                            miss_d  = 1'b1;
                            wrong_d = wrong_q + WRONG_W'(1);
                        end
                    end
                end
`ifdef GUESS_ENGINE_HINT_EN
            end else if (bus.hint) begin
                guessed_d = guessed_q | reveal;
                wrong_d   = wrong_q + WRONG_W'(1);
                eval      = 1'b1;
`endif
            end

            // Outcome uses the post-update mask/count so it lands on the same edge;
            // a completed word beats a simultaneous final miss.
            if (eval) begin
                if ((guessed_d & target_q) == target_q) begin
                    state_d = ST_WON;
                    wins_d  = (wins_q == 8'hFF) ? wins_q : wins_q + 8'd1;
                end else if (wrong_d == WRONG_W'(MAX_WRONG)) begin
                    state_d  = ST_LOST;
                    losses_d = (losses_q == 8'hFF) ? losses_q : losses_q + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            target_q  <= '0;
            guessed_q <= '0;
            wrong_q   <= '0;
            wins_q    <= '0;
            losses_q  <= '0;
            hit_q     <= 1'b0;
            miss_q    <= 1'b0;
            rep_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            target_q  <= target_d;
            guessed_q <= guessed_d;
            wrong_q   <= wrong_d;
            wins_q    <= wins_d;
            losses_q  <= losses_d;
            hit_q     <= hit_d;
            miss_q    <= miss_d;
            rep_q     <= rep_d;
        end
    end

    assign bus.guessed_mask = guessed_q;
    assign bus.game_state   = state_q;
    assign bus.wrong_time   = wrong_q;
    assign bus.hit          = hit_q;
    assign bus.miss         = miss_q;
    assign bus.repeat_guess = rep_q;
    assign bus.wins         = wins_q;
    assign bus.losses       = losses_q;

endmodule

// File: tb/tb_guess_engine.sv
// Directed bench for guess_engine: rounds won, lost, repeats, restarts, reset, saturation.
// Latency: inputs are driven 1 ns after a rising edge, outputs checked 1 ns after the next.
// Backpressure: none; stimulus is a fixed cycle-by-cycle script.
module tb_guess_engine;

    localparam logic [25:0] CAT = 26'h0080005;

    logic clk;
    logic resetn;
    int   tests;
    int   errors;

    guess_engine_if #(.ALPHA(26), .LETTER_W(5), .WRONG_W(4)) bus ();

    guess_engine #(
        .ALPHA(26), .LETTER_W(5), .MAX_WRONG(6), .WRONG_W(4)
    ) u_dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_round(input logic [25:0] t);
        bus.start       = 1'b1;
        bus.target_mask = t;
        tick();
        bus.start       = 1'b0;
    endtask

    task automatic guess(input logic [4:0] x);
        bus.load   = 1'b1;
        bus.load_x = x;
        tick();
        bus.load   = 1'b0;
    endtask

    task automatic check_strobes(input string tag, input logic h, input logic m, input logic r);
        check({tag, ".strobes"}, {29'd0, bus.hit, bus.miss, bus.repeat_guess}, {29'd0, h, m, r});
    endtask

    initial begin
        tests  = 0;
        errors = 0;
        resetn = 1'b0;
        bus.start       = 1'b0;
        bus.target_mask = '0;
        bus.load        = 1'b0;
        bus.load_x      = '0;
`ifdef GUESS_ENGINE_HINT_EN
        bus.hint        = 1'b0;
`endif
        tick();
        tick();
        check("rst.state",  bus.game_state, 2'b00);
        check("rst.mask",   bus.guessed_mask, 0);
        check("rst.wrong",  bus.wrong_time, 0);
        check("rst.wins",   bus.wins, 0);
        check("rst.losses", bus.losses, 0);
        check_strobes("rst", 0, 0, 0);
        resetn = 1'b1;
        tick();

        // Load in IDLE does nothing.
        guess(5'd2);
        check_strobes("idle_load", 0, 0, 0);
        check("idle_load.mask", bus.guessed_mask, 0);

        // Win round: CAT.
        start_round(CAT);
        check("cat.state_play", bus.game_state, 2'b01);
        guess(5'd2);
        check_strobes("cat.C", 1, 0, 0);
        check("cat.C.mask", bus.guessed_mask, 32'h4);
        guess(5'd0);
        check_strobes("cat.A", 1, 0, 0);
        check("cat.A.state", bus.game_state, 2'b01);
        guess(5'd19);
        check_strobes("cat.T", 1, 0, 0);
        check("cat.T.mask", bus.guessed_mask, 32'h0080005);
        check("cat.T.state", bus.game_state, 2'b10);
        check("cat.T.wins", bus.wins, 1);
        tick();
        check_strobes("cat.strobe_drop", 0, 0, 0);

        // Empty start in WON is ignored.
        start_round('0);
        check("zero_start.state", bus.game_state, 2'b10);
        check("zero_start.mask", bus.guessed_mask, 32'h0080005);

        // start + load together: start wins, load dropped.
        bus.load   = 1'b1;
        bus.load_x = 5'd25;
        start_round(CAT);
        bus.load   = 1'b0;
        check("start_load.state", bus.game_state, 2'b01);
        check("start_load.mask", bus.guessed_mask, 0);
        check("start_load.wrong", bus.wrong_time, 0);
        check_strobes("start_load", 0, 0, 0);

        // Repeat guess and out-of-range letter.
        guess(5'd1);
        check_strobes("B1", 0, 1, 0);
        check("B1.wrong", bus.wrong_time, 1);
        guess(5'd1);
        check_strobes("B2", 0, 0, 1);
        check("B2.wrong", bus.wrong_time, 1);
        guess(5'd27);
        check_strobes("x27", 0, 0, 0);
        check("x27.mask", bus.guessed_mask, 32'h2);
        check("x27.wrong", bus.wrong_time, 1);

        // Held load: first cycle hit, second cycle repeat.
        bus.load   = 1'b1;
        bus.load_x = 5'd0;
        tick();
        check_strobes("held1", 1, 0, 0);
        tick();
        check_strobes("held2", 0, 0, 1);
        bus.load   = 1'b0;

        // Lose round: six misses Z..U.
        start_round(CAT);
        for (int i = 0; i < 6; i++) begin
            guess(5'(25 - i));
            check_strobes($sformatf("lose%0d", i), 0, 1, 0);
            check($sformatf("lose%0d.wrong", i), bus.wrong_time, i + 1);
        end
        check("lose.state", bus.game_state, 2'b11);
        check("lose.losses", bus.losses, 1);
        check("lose.mask", bus.guessed_mask, 32'h3F00000);
        guess(5'd2);
        check_strobes("lost_load", 0, 0, 0);
        check("lost_load.mask", bus.guessed_mask, 32'h3F00000);
        check("lost_load.state", bus.game_state, 2'b11);

`ifdef GUESS_ENGINE_HINT_EN
        // Hint reveals A (lowest unguessed target letter) for a one-miss penalty.
        start_round(CAT);
        guess(5'd2);
        bus.hint = 1'b1;
        tick();
        bus.hint = 1'b0;
        check("hint.mask", bus.guessed_mask, 32'h5);
        check("hint.wrong", bus.wrong_time, 1);
        check_strobes("hint", 0, 0, 0);
        // Load beats hint in the same cycle.
        bus.hint = 1'b1;
        guess(5'd25);
        bus.hint = 1'b0;
        check_strobes("hint_load", 0, 1, 0);
        check("hint_load.mask", bus.guessed_mask, 32'h2000005);
        check("hint_load.wrong", bus.wrong_time, 2);
`endif

        // Async reset mid-round while a miss strobe is high.
        start_round(CAT);
        guess(5'd25);
        guess(5'd24);
        guess(5'd23);
        check("pre_rst.wrong", bus.wrong_time, 3);
        check_strobes("pre_rst", 0, 1, 0);
        resetn = 1'b0;
        #1;
        check("arst.state",  bus.game_state, 2'b00);
        check("arst.mask",   bus.guessed_mask, 0);
        check("arst.wrong",  bus.wrong_time, 0);
        check("arst.losses", bus.losses, 0);
        check_strobes("arst", 0, 0, 0);
        tick();
        resetn = 1'b1;
        tick();

        // Win counter saturation: 257 single-letter rounds.
        for (int i = 0; i < 257; i++) begin
            start_round(26'h1);
            guess(5'd0);
            if (i == 254) check("sat.wins255", bus.wins, 255);
        end
        check("sat.wins", bus.wins, 255);
        check("sat.state", bus.game_state, 2'b10);
        check("sat.losses", bus.losses, 0);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
